// File: rtl/ui_debounce.sv
// ui_debounce: two-flop synchroniser plus independent per-bit debounce of the
// raw input pins. Outputs a clean level vector and one-cycle rise/fall pulses.

// Debounce lane for one bit. clean follows sync only after the mismatch has
// persisted for DEBOUNCE_CYCLES qualified ticks.
module ui_debounce_lane #(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  input  logic tick,
  output logic clean,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Any match restarts the count; a full run of mismatched ticks accepts the
  // new level and fires a pulse in the direction of the change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      clean <= RESET_BIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync == clean) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          clean <= sync;
          cnt   <= '0;
          rise  <= sync;
          fall  <= ~sync;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

module ui_debounce #(
  parameter int               WIDTH           = 8,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             tick,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);
  logic [WIDTH-1:0] sync1, sync2;

  // Two-stage synchroniser; only sync2 is safe to use downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    ui_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_BIT      (RESET_VALUE[g])
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .sync (sync2[g]),
      .tick (tick),
      .clean(clean_out[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

  assign changed = |(rise | fall);
endmodule

// File: doc/ui_debounce.md
# ui_debounce

Input-conditioning stage that sits directly upstream of the doodle logic on the dedicated input bus. It takes the raw `ui_in` pins (slide switches and push-buttons on the demo board), synchronises them into the `clk` domain, and debounces each bit independently. It presents a clean, glitch-free 8-bit vector plus one-cycle rise/fall event pulses for the downstream gate/flop doodle to consume. Without it, the doodle's flops clock in bounce and metastable values.

## Interface

Parameters:
- `WIDTH`, 8: number of independent input bits.
- `DEBOUNCE_CYCLES`, 16: stable ticks required before `clean_out` accepts a new level; legal range 1..65535.
- `RESET_VALUE`, 8'h00: value of sync stages and `clean_out` during and after reset.

Ports:
- `clk`  input  1  single clock; all state on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `raw_in`  input  WIDTH  asynchronous pin levels, normally `ui_in`.
- `tick`  input  1  counter-advance qualifier (prescaler strobe); tie to 1 for per-clock debounce.
- `clean_out`  output  WIDTH  debounced level, registered.
- `rise`  output  WIDTH  one-cycle pulse per bit when `clean_out[i]` goes 0->1, registered.
- `fall`  output  WIDTH  one-cycle pulse per bit when `clean_out[i]` goes 1->0, registered.
- `changed`  output  1  OR-reduction of `rise | fall`; combinational from registers only.

## Operation

- Synchroniser: two flops per bit (`sync1 <= raw_in`, `sync2 <= sync1`). Both reset to `RESET_VALUE`. Only `sync2` is used downstream.
- Per-bit counter `cnt[i]`, width `$clog2(DEBOUNCE_CYCLES+1)`, resets to 0.
- Per-bit update each clock, evaluated in priority order:
  - `sync2[i] == clean_out[i]`: `cnt[i] <= 0`, regardless of `tick`. Any bounce back restarts the count.
  - mismatch, `tick` = 1, `cnt[i] == DEBOUNCE_CYCLES-1`: `clean_out[i] <= sync2[i]`, `cnt[i] <= 0`, and pulse `rise[i]` or `fall[i]` according to the new value.
  - mismatch, `tick` = 1, otherwise: `cnt[i] <= cnt[i] + 1`.
  - mismatch, `tick` = 0: hold `cnt[i]`.
- `rise`/`fall` are cleared every cycle unless set by the accept rule. A bit can never have `rise[i]` and `fall[i]` asserted together.
- Bits are fully independent. Simultaneous accepts on several bits produce pulses in the same cycle.
- Counter never exceeds `DEBOUNCE_CYCLES-1` and never wraps.

## Timing

- Reset, asynchronous: `clean_out = RESET_VALUE`, `rise = fall = 0`, `changed = 0`, all `cnt = 0`, sync flops = `RESET_VALUE`.
- Reset asserted mid-count: the count is discarded immediately and no pulse is emitted.
- After reset release: if `raw_in` differs from `RESET_VALUE`, that bit debounces normally and emits a pulse on acceptance.
- Latency, with `tick` = 1 and `raw_in` stable from the edge that first samples it (E0):
  - `sync2` updates at E1.
  - `clean_out` and the pulse update at E(1+`DEBOUNCE_CYCLES`), i.e. `DEBOUNCE_CYCLES`+1 edges after E0.
- Rejection: a `sync2` mismatch lasting fewer than `DEBOUNCE_CYCLES` ticks never reaches `clean_out`.
- `tick` gaps stretch latency by exactly the number of mismatch cycles with `tick` = 0.
- Pulses last exactly one `clk` cycle. They are coincident with the `clean_out` edge and visible in the cycle after the accepting edge.
- `DEBOUNCE_CYCLES` = 1: accept on the first mismatched tick, 2-edge latency.

## Test plan

1. Reset check, `RESET_VALUE` = 8'h00, `raw_in` = 8'hFF during reset:
   - `clean_out` = 0 and `rise` = `fall` = 0 throughout reset.
   - After release, `clean_out` = 8'hFF exactly `DEBOUNCE_CYCLES`+1 edges after the first sampling edge, with `rise` = 8'hFF for one cycle.
2. Clean step, `DEBOUNCE_CYCLES` = 4, `tick` = 1, `raw_in[2]` 0->1:
   - `clean_out[2]` rises 5 edges after first sample.
   - `rise` = 8'h04 for 1 cycle, `changed` = 1 for 1 cycle, all other bits unchanged.
3. Bounce rejection, `DEBOUNCE_CYCLES` = 4:
   - `raw_in[0]` toggles 1,0,1,0 with a 3-cycle period, then settles at 1.
   - `clean_out[0]` stays 0 until 5 edges after the final settle, then exactly one `rise[0]` pulse.
4. `tick` qualification, `DEBOUNCE_CYCLES` = 4, `tick` high every 3rd cycle, `raw_in[7]` 1->0 from `clean_out` = 8'h80:
   - Acceptance occurs at the edge of the 4th tick after `sync2` mismatches.
   - `fall` = 8'h80 for 1 cycle.
5. Simultaneous events: `raw_in` 8'h0F -> 8'hF0 in one step:
   - Same-cycle `rise` = 8'hF0 and `fall` = 8'h0F; `clean_out` = 8'hF0.
6. Reset mid-count: assert `rst` when `cnt[3]` = 2:
   - `clean_out` returns to `RESET_VALUE` asynchronously and no pulse appears.
   - After release, a stable input re-debounces from `cnt` = 0, with full latency.
